// File: rtl/round_robin_lock_arbiter.sv
// Locking N-port arbiter. A registered one-hot grant is held until the holder
// releases, drops its request, or reaches the MAX_HOLD cycle limit. The winner
// of each arbitration comes from a fixed-priority or a round-robin policy.
module round_robin_lock_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned MODE_RR   = 1,
    parameter int unsigned MAX_HOLD  = 16,
    localparam int unsigned IDW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_PORTS-1:0] requests_i,
    input  logic                 release_i,
    output logic [NUM_PORTS-1:0] grants_o,
    output logic                 grant_valid_o,
    output logic [IDW-1:0]       grant_id_o,
    output logic                 timeout_o
);

    // Hold counter width; one bit minimum so an unlimited hold still elaborates.
    localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    // Counter value seen during the last permitted cycle of a grant.
    localparam logic [HW-1:0] HoldLast = (MAX_HOLD != 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [IDW-1:0] LastId = IDW'(NUM_PORTS - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e               r_state;
    state_e               w_state_next;

    logic [NUM_PORTS-1:0] r_grants;
    logic [IDW-1:0]       r_id;
    logic [IDW-1:0]       r_ptr;
    logic [HW-1:0]        r_hold;
    logic                 r_timeout;

    logic                 w_any_req;
    logic                 w_holder_req;
    logic                 w_expire;
    logic                 w_release_evt;
    logic                 w_forced;
    logic [NUM_PORTS-1:0] w_mask;
    logic [NUM_PORTS-1:0] w_masked;
    logic [NUM_PORTS-1:0] w_pool;
    logic                 w_win_found;
    logic [IDW-1:0]       w_win_id;
    logic [NUM_PORTS-1:0] w_win_onehot;
    logic [IDW-1:0]       w_ptr_next;
    logic                 w_load;

    // Decode the release conditions of the current holder.
    always_comb begin
        w_any_req     = |requests_i;
        w_holder_req  = requests_i[r_id];
        w_expire      = (MAX_HOLD != 0) && (r_hold == HoldLast);
        w_release_evt = (r_state == StGrant) && (release_i || !w_holder_req || w_expire);
        // Only a timeout on a still-requesting holder that did not release is a forced release.
        w_forced      = (r_state == StGrant) && w_expire && !release_i && w_holder_req;
    end

    // Build the arbitration pool; a forced-off holder sits out one round unless it is alone.
    always_comb begin
        w_mask = '0;
        if (w_forced) begin
            w_mask[r_id] = 1'b1;
        end
        w_masked = requests_i & ~w_mask;
        w_pool   = (w_masked != '0) ? w_masked : requests_i;
    end

    // Pick the winner: scan from the rotating pointer (RR) or from index 0 (fixed).
    always_comb begin : p_pick
        int unsigned v_idx;
        w_win_found = 1'b0;
        w_win_id    = '0;
        v_idx       = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (MODE_RR != 0) begin
                v_idx = (32'(r_ptr) + k) % NUM_PORTS;
            end else begin
                v_idx = k;
            end
            if (!w_win_found && w_pool[IDW'(v_idx)]) begin
                w_win_found = 1'b1;
                w_win_id    = IDW'(v_idx);
            end
        end
    end

    // One-hot form of the winner and the pointer that follows it.
    always_comb begin
        w_win_onehot           = '0;
        w_win_onehot[w_win_id] = w_win_found;
        w_ptr_next             = (w_win_id == LastId) ? '0 : w_win_id + 1'b1;
        w_load                 = w_any_req && ((r_state == StIdle) || w_release_evt);
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave GRANT only when a release finds nobody requesting.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_next = StGrant;
                end
            end
            StGrant: begin
                if (w_release_evt && !w_any_req) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Grant, pointer, hold counter and timeout pulse registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_grants  <= '0;
            r_id      <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_forced;
            if (w_load) begin
                r_grants <= w_win_onehot;
                r_id     <= w_win_id;
                r_ptr    <= w_ptr_next;
                r_hold   <= '0;
            end else if (w_release_evt) begin
                r_grants <= '0;
                r_id     <= '0;
                r_hold   <= '0;
            end else if ((r_state == StGrant) && (MAX_HOLD != 0) && !w_expire) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        grants_o      = r_grants;
        grant_valid_o = |r_grants;
        grant_id_o    = r_id;
        timeout_o     = r_timeout;
    end

endmodule

// File: tb/tb_round_robin_lock_arbiter.sv
// Bench for round_robin_lock_arbiter: one round-robin and one fixed-priority
// instance share stimulus; both are compared every cycle against a
// cycle-level reference model, with extra directed checks along the way.
module tb_round_robin_lock_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       reset;
    logic [3:0] requests;
    logic       rel_in;

    logic [3:0] grants [2];
    logic       valid  [2];
    logic [1:0] gid    [2];
    logic       tmo    [2];

    int checks;
    int errors;

    // Model state per instance: 0 = round-robin, 1 = fixed priority.
    int holder [2];  // -1 when idle
    int ptr    [2];
    int cnt    [2];  // cycles granted so far to the current holder
    bit to     [2];

    round_robin_lock_arbiter #(
        .NUM_PORTS (N),
        .MODE_RR   (1),
        .MAX_HOLD  (MAX_HOLD)
    ) dut_rr (
        .clk_i         (clk),
        .reset_i       (reset),
        .requests_i    (requests),
        .release_i     (rel_in),
        .grants_o      (grants[0]),
        .grant_valid_o (valid[0]),
        .grant_id_o    (gid[0]),
        .timeout_o     (tmo[0])
    );

    round_robin_lock_arbiter #(
        .NUM_PORTS (N),
        .MODE_RR   (0),
        .MAX_HOLD  (MAX_HOLD)
    ) dut_fx (
        .clk_i         (clk),
        .reset_i       (reset),
        .requests_i    (requests),
        .release_i     (rel_in),
        .grants_o      (grants[1]),
        .grant_valid_o (valid[1]),
        .grant_id_o    (gid[1]),
        .timeout_o     (tmo[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            holder[m] = -1;
            ptr[m]    = 0;
            cnt[m]    = 0;
            to[m]     = 1'b0;
        end
    endfunction

    // One clock of the arbitration rules, applied to the inputs seen at the edge.
    function automatic void model_update(int m, logic [3:0] req, logic rel);
        bit         need;
        bit         forced;
        bit         drop;
        bit         expired;
        logic [3:0] pool;
        logic [3:0] others;
        int         w;
        int         p;
        forced = 1'b0;
        need   = 1'b1;
        if (holder[m] >= 0) begin
            drop    = !req[holder[m]];
            expired = (cnt[m] == MAX_HOLD);
            need    = rel || drop || expired;
            forced  = expired && !rel && !drop;
        end
        to[m] = forced;
        if (!need) begin
            cnt[m]++;
            return;
        end
        pool = req;
        if (forced) begin
            others = req & ~(4'b0001 << holder[m]);
            if (others != 4'b0000) pool = others;
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            p = (m == 0) ? (ptr[m] + k) % N : k;
            if (w < 0 && pool[p]) w = p;
        end
        holder[m] = w;
        if (w >= 0) begin
            ptr[m] = (w + 1) % N;
            cnt[m] = 1;
        end else begin
            cnt[m] = 0;
        end
    endfunction

    task automatic check_all();
        logic [3:0] eg;
        logic [1:0] eid;
        for (int m = 0; m < 2; m++) begin
            eg  = (holder[m] < 0) ? 4'b0000 : 4'(4'b0001 << holder[m]);
            eid = (holder[m] < 0) ? 2'd0 : 2'(holder[m]);
            chk($sformatf("grants[%0d]", m), 32'(grants[m]), 32'(eg));
            chk($sformatf("valid[%0d]", m), 32'(valid[m]), 32'(holder[m] >= 0));
            chk($sformatf("id[%0d]", m), 32'(gid[m]), 32'(eid));
            chk($sformatf("timeout[%0d]", m), 32'(tmo[m]), 32'(to[m]));
        end
    endtask

    task automatic step(input logic [3:0] req, input logic rel);
        requests = req;
        rel_in   = rel;
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_update(m, req, rel);
        #1;
        check_all();
    endtask

    // Assert reset between edges, confirm the grant clears at once, release at a negedge.
    task automatic do_reset(input logic [3:0] req);
        requests = req;
        rel_in   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] rq;
    logic [3:0] rr_seq [4];

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        requests = 4'b1111;
        rel_in   = 1'b0;
        model_reset();

        // Reset with all requesters active: everything stays zero.
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step(4'b1111, 1'b0);
        chk("t1_first_grant", 32'(grants[0]), 32'h1);
        chk("t1_first_id", 32'(gid[0]), 32'h0);

        // Round-robin rotation with a release pulse per grant, no idle gaps.
        rr_seq[0] = 4'b0010;
        rr_seq[1] = 4'b0100;
        rr_seq[2] = 4'b1000;
        rr_seq[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 1'b1);
            chk($sformatf("t2_rot%0d", i), 32'(grants[0]), 32'(rr_seq[i]));
            chk($sformatf("t2_fixed%0d", i), 32'(grants[1]), 32'h1);
        end

        // Wrap: walk to port 3, then 0101 picks port 0, then port 2.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        chk("t5_at_port3", 32'(grants[0]), 32'h8);
        step(4'b0101, 1'b0);
        chk("t5_wrap_port0", 32'(grants[0]), 32'h1);
        step(4'b0101, 1'b1);
        chk("t5_then_port2", 32'(grants[0]), 32'h4);

        // Async reset mid-grant; pointer back to 0 so 1100 picks port 2.
        do_reset(4'b1100);
        chk("t6_cleared", 32'(grants[0]), 32'h0);
        step(4'b1100, 1'b0);
        chk("t6_after_reset", 32'(grants[0]), 32'h4);

        // Fixed priority: 1010 always goes to port 1.
        for (int i = 0; i < 4; i++) begin
            step(4'b1010, 1'b1);
            chk($sformatf("t3_fixed%0d", i), 32'(grants[1]), 32'h2);
        end

        // Hold limit: port 0 exactly MAX_HOLD cycles, then port 1 with a timeout pulse.
        step(4'b0000, 1'b0);
        chk("t4_idle", 32'(valid[1]), 32'h0);
        for (int i = 0; i < MAX_HOLD; i++) begin
            step(4'b0011, 1'b0);
            chk($sformatf("t4_hold%0d", i), 32'(grants[1]), 32'h1);
            chk($sformatf("t4_no_to%0d", i), 32'(tmo[1]), 32'h0);
        end
        step(4'b0011, 1'b0);
        chk("t4_switch", 32'(grants[1]), 32'h2);
        chk("t4_to_pulse", 32'(tmo[1]), 32'h1);
        step(4'b0011, 1'b0);
        chk("t4_to_single", 32'(tmo[1]), 32'h0);

        // Sole requester timing out is re-granted.
        step(4'b0100, 1'b1);
        for (int i = 0; i < MAX_HOLD; i++) step(4'b0100, 1'b0);
        chk("sole_regrant", 32'(grants[1]), 32'h4);
        chk("sole_to", 32'(tmo[1]), 32'h1);

        // Randomised traffic with sticky requests so timeouts occur.
        rq = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) begin
                do_reset(rq);
            end else begin
                step(rq, ($urandom_range(0, 4) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
